// File: rtl/serial_arith_pkg.sv
// ---------------------------------------------------------------------------
// serial_arith_pkg
// Shared definitions for the bit-serial arithmetic blocks.
//   state_t   : controller state encoding (IDLE / SHIFT / FINISH)
//   DEFAULT_N : default operand width
//   CNT_W     : bit-counter width, wide enough for operands up to 32 bits
// ---------------------------------------------------------------------------
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int DEFAULT_N = 8;
    localparam int CNT_W     = 6;

endpackage

// File: rtl/serial_subtractor_fullsubtractor.sv
// ---------------------------------------------------------------------------
// fullsubtractor
// One-bit combinational full subtractor computing X - Y - BIN.
// Ports:
//   X, Y  : operand bits
//   BIN   : borrow in
//   D     : difference bit
//   BOUT  : borrow out
// ---------------------------------------------------------------------------
module fullsubtractor (
    input  logic X,
    input  logic Y,
    input  logic BIN,
    output logic D,
    output logic BOUT
);

    assign D    = X ^ Y ^ BIN;
    assign BOUT = (~X & Y) | (~(X ^ Y) & BIN);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial subtractor: one START pulse captures X and Y, the operands are
// processed LSB-first for N cycles, and the registered result is published
// with a one-cycle DONE pulse. D and B hold until the next completion.
//
// Optional feature (macro SERIAL_SUBTRACTOR_ADD_EN): adds a MODE input,
// captured with START; MODE=1 adds instead of subtracting and B then reports
// the carry-out.
//
// Ports:
//   CLK   : rising-edge clock
//   RST   : asynchronous active-high reset
//   START : request pulse, only looked at in IDLE
//   MODE  : (SERIAL_SUBTRACTOR_ADD_EN only) 0 = subtract, 1 = add
//   X, Y  : minuend / subtrahend
//   D     : registered result, X - Y mod 2^N
//   B     : registered final borrow (X < Y unsigned) or carry in add mode
//   BUSY  : high in SHIFT and FINISH
//   DONE  : one-cycle pulse marking D/B valid
// ---------------------------------------------------------------------------
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
`ifdef SERIAL_SUBTRACTOR_ADD_EN
    input  logic         MODE,
`endif
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    output logic [N-1:0] D,
    output logic         B,
    output logic         BUSY,
    output logic         DONE
);

    state_t             state;
    logic [N-1:0]       x_sh;
    logic [N-1:0]       y_sh;
    logic [N-1:0]       res;
    logic               borrow;
    logic [CNT_W-1:0]   cnt;
    logic               sub_d;
    logic               sub_bout;
    logic               bit_d;
    logic               bit_c;

    fullsubtractor u_cell (
        .X    (x_sh[0]),
        .Y    (y_sh[0]),
        .BIN  (borrow),
        .D    (sub_d),
        .BOUT (sub_bout)
    );

`ifdef SERIAL_SUBTRACTOR_ADD_EN
    logic mode_r;
    logic add_s;
    logic add_c;

    // The borrow flop doubles as the carry flop in add mode.
    assign add_s = x_sh[0] ^ y_sh[0] ^ borrow;
    assign add_c = (x_sh[0] & y_sh[0]) | (borrow & (x_sh[0] ^ y_sh[0]));
    assign bit_d = mode_r ? add_s : sub_d;
    assign bit_c = mode_r ? add_c : sub_bout;
`else
    assign bit_d = sub_d;
    assign bit_c = sub_bout;
`endif

    // Controller and datapath. D, B and DONE only change in FINISH, so the
    // published result stays put while the next operation is running.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            x_sh   <= '0;
            y_sh   <= '0;
            res    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            D      <= '0;
            B      <= 1'b0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_ADD_EN
            mode_r <= 1'b0;
`endif
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        x_sh   <= X;
                        y_sh   <= Y;
                        res    <= '0;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        BUSY   <= 1'b1;
`ifdef SERIAL_SUBTRACTOR_ADD_EN
                        mode_r <= MODE;
`endif
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    // New bit enters at the MSB so after N shifts bit 0 of
                    // the operands has landed in res[0].
                    res    <= {bit_d, res[N-1:1]};
                    x_sh   <= x_sh >> 1;
                    y_sh   <= y_sh >> 1;
                    borrow <= bit_c;
                    if (cnt == CNT_W'(N - 1)) begin
                        state <= FINISH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FINISH: begin
                    D     <= res;
                    B     <= borrow;
                    DONE  <= 1'b1;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
// Directed self-checking bench for serial_subtractor. An N=8 instance covers
// the main scenarios; an N=4 instance runs an exhaustive back-to-back sweep.
// Inputs change on the falling edge and outputs are sampled there too.
// Define SERIAL_SUBTRACTOR_ADD_EN to also exercise the add mode.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

    logic       clk;
    logic       rst;

    logic       start8;
    logic       mode8;
    logic [7:0] x8;
    logic [7:0] y8;
    logic [7:0] d8;
    logic       b8;
    logic       busy8;
    logic       done8;

    logic       start4;
    logic       mode4;
    logic [3:0] x4;
    logic [3:0] y4;
    logic [3:0] d4;
    logic       b4;
    logic       busy4;
    logic       done4;

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_subtractor #(.N(8)) dut8 (
        .CLK   (clk),
        .RST   (rst),
        .START (start8),
`ifdef SERIAL_SUBTRACTOR_ADD_EN
        .MODE  (mode8),
`endif
        .X     (x8),
        .Y     (y8),
        .D     (d8),
        .B     (b8),
        .BUSY  (busy8),
        .DONE  (done8)
    );

    serial_subtractor #(.N(4)) dut4 (
        .CLK   (clk),
        .RST   (rst),
        .START (start4),
`ifdef SERIAL_SUBTRACTOR_ADD_EN
        .MODE  (mode4),
`endif
        .X     (x4),
        .Y     (y4),
        .D     (d4),
        .B     (b4),
        .BUSY  (busy4),
        .DONE  (done4)
    );

    // Pulses START on the N=8 instance and waits (bounded) for DONE.
    // cyc = falling edges from the START-sampling edge to DONE (-1 on timeout),
    // busy_n = number of sampled cycles with BUSY high.
    task automatic run_op8(input logic [7:0] xa, input logic [7:0] ya,
                           input logic m, output logic [7:0] dv,
                           output logic bv, output int cyc, output int busy_n);
        x8     = xa;
        y8     = ya;
        mode8  = m;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        busy_n = busy8 ? 1 : 0;
        cyc    = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy8) busy_n++;
            if (done8) begin
                cyc = k;
                break;
            end
        end
        dv = d8;
        bv = b8;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (d8 !== 8'd0)   begin failures++; $display("[TB] FAIL reset_d got=%0d want=0", d8); end
        checks++; if (b8 !== 1'b0)   begin failures++; $display("[TB] FAIL reset_b got=%b want=0", b8); end
        checks++; if (busy8 !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", busy8); end
        checks++; if (done8 !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b want=0", done8); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [7:0] dv;
        logic       bv;
        int         cyc;
        int         bn;
        run_op8(8'd100, 8'd58, 1'b0, dv, bv, cyc, bn);
        checks++; if (cyc !== 9)    begin failures++; $display("[TB] FAIL basic_latency got=%0d want=9", cyc); end
        checks++; if (bn !== 9)     begin failures++; $display("[TB] FAIL basic_busy_cycles got=%0d want=9", bn); end
        checks++; if (dv !== 8'd42) begin failures++; $display("[TB] FAIL basic_d got=%0d want=42", dv); end
        checks++; if (bv !== 1'b0)  begin failures++; $display("[TB] FAIL basic_b got=%b want=0", bv); end
        @(negedge clk);
        checks++; if (done8 !== 1'b0) begin failures++; $display("[TB] FAIL done_one_cycle got=%b want=0", done8); end
        repeat (3) @(negedge clk);
        checks++; if (d8 !== 8'd42) begin failures++; $display("[TB] FAIL d_hold got=%0d want=42", d8); end
    endtask

    task automatic test_borrow;
        logic [7:0] dv;
        logic       bv;
        int         cyc;
        int         bn;
        run_op8(8'd5, 8'd10, 1'b0, dv, bv, cyc, bn);
        checks++; if (dv !== 8'd251) begin failures++; $display("[TB] FAIL borrow_d got=%0d want=251", dv); end
        checks++; if (bv !== 1'b1)   begin failures++; $display("[TB] FAIL borrow_b got=%b want=1", bv); end
        @(negedge clk);
        run_op8(8'd0, 8'd0, 1'b0, dv, bv, cyc, bn);
        checks++; if (dv !== 8'd0)   begin failures++; $display("[TB] FAIL zero_d got=%0d want=0", dv); end
        checks++; if (bv !== 1'b0)   begin failures++; $display("[TB] FAIL zero_b got=%b want=0", bv); end
        checks++; if (cyc !== 9)     begin failures++; $display("[TB] FAIL zero_latency got=%0d want=9", cyc); end
    endtask

    task automatic test_ignore_start;
        int cyc;
        @(negedge clk);
        x8 = 8'd100; y8 = 8'd58; mode8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        cyc = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 3) begin
                x8 = 8'd7; y8 = 8'd200; start8 = 1'b1;
            end
            if (k == 4) start8 = 1'b0;
            @(negedge clk);
            if (done8) begin
                cyc = k;
                break;
            end
        end
        checks++; if (cyc !== 9)     begin failures++; $display("[TB] FAIL ignore_latency got=%0d want=9", cyc); end
        checks++; if (d8 !== 8'd42)  begin failures++; $display("[TB] FAIL ignore_d got=%0d want=42", d8); end
        checks++; if (b8 !== 1'b0)   begin failures++; $display("[TB] FAIL ignore_b got=%b want=0", b8); end
        @(negedge clk);
        checks++; if (busy8 !== 1'b0) begin failures++; $display("[TB] FAIL ignore_idle_busy got=%b want=0", busy8); end
    endtask

    task automatic test_reset_abort;
        logic [7:0] dv;
        logic       bv;
        int         cyc;
        int         bn;
        int         done_seen;
        @(negedge clk);
        x8 = 8'd50; y8 = 8'd20; mode8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++; if (d8 !== 8'd0)    begin failures++; $display("[TB] FAIL abort_d got=%0d want=0", d8); end
        checks++; if (b8 !== 1'b0)    begin failures++; $display("[TB] FAIL abort_b got=%b want=0", b8); end
        checks++; if (busy8 !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy got=%b want=0", busy8); end
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done8) done_seen++;
        end
        checks++; if (done_seen !== 0) begin failures++; $display("[TB] FAIL abort_no_done got=%0d want=0", done_seen); end
        run_op8(8'd200, 8'd1, 1'b0, dv, bv, cyc, bn);
        checks++; if (dv !== 8'd199) begin failures++; $display("[TB] FAIL after_abort_d got=%0d want=199", dv); end
        checks++; if (bv !== 1'b0)   begin failures++; $display("[TB] FAIL after_abort_b got=%b want=0", bv); end
        checks++; if (cyc !== 9)     begin failures++; $display("[TB] FAIL after_abort_latency got=%0d want=9", cyc); end
    endtask

`ifdef SERIAL_SUBTRACTOR_ADD_EN
    task automatic test_mode;
        logic [7:0] dv;
        logic       bv;
        int         cyc;
        int         bn;
        @(negedge clk);
        run_op8(8'd200, 8'd100, 1'b1, dv, bv, cyc, bn);
        checks++; if (dv !== 8'd44)  begin failures++; $display("[TB] FAIL add_d got=%0d want=44", dv); end
        checks++; if (bv !== 1'b1)   begin failures++; $display("[TB] FAIL add_carry got=%b want=1", bv); end
        @(negedge clk);
        run_op8(8'd200, 8'd100, 1'b0, dv, bv, cyc, bn);
        checks++; if (dv !== 8'd100) begin failures++; $display("[TB] FAIL sub_mode_d got=%0d want=100", dv); end
        checks++; if (bv !== 1'b0)   begin failures++; $display("[TB] FAIL sub_mode_b got=%b want=0", bv); end
    endtask
`endif

    // All 256 N=4 operand pairs, each START issued in the cycle DONE of the
    // previous operation is high, so the period is N+2 = 6 cycles.
    task automatic test_back_to_back;
        logic [3:0] ex_d;
        logic       ex_b;
        int         cyc;
        string      row;
        @(negedge clk);
        mode4  = 1'b0;
        x4     = 4'd0;
        y4     = 4'd0;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        row = "";
        for (int idx = 0; idx < 256; idx++) begin
            ex_d = 4'(idx[7:4] - idx[3:0]);
            ex_b = (idx[7:4] < idx[3:0]);
            cyc = -1;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (done4) begin
                    cyc = k;
                    break;
                end
            end
            checks++; if (cyc !== 5)   begin failures++; $display("[TB] FAIL b2b_period x=%0d y=%0d got=%0d want=5", idx[7:4], idx[3:0], cyc); end
            checks++; if (d4 !== ex_d) begin failures++; $display("[TB] FAIL b2b_d x=%0d y=%0d got=%0d want=%0d", idx[7:4], idx[3:0], d4, ex_d); end
            checks++; if (b4 !== ex_b) begin failures++; $display("[TB] FAIL b2b_b x=%0d y=%0d got=%b want=%b", idx[7:4], idx[3:0], b4, ex_b); end
            row = {row, $sformatf(" %0d/%0d", d4, b4)};
            if (idx[3:0] == 4'd15) begin
                $display("[TB] x=%0d d/b:%s", idx[7:4], row);
                row = "";
            end
            if (idx < 255) begin
                x4     = 4'((idx + 1) >> 4);
                y4     = 4'((idx + 1) & 15);
                start4 = 1'b1;
                @(negedge clk);
                start4 = 1'b0;
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        start8 = 1'b0;
        mode8  = 1'b0;
        x8     = '0;
        y8     = '0;
        start4 = 1'b0;
        mode4  = 1'b0;
        x4     = '0;
        y4     = '0;
        test_reset();
        test_basic();
        test_borrow();
        test_ignore_start();
        test_reset_abort();
`ifdef SERIAL_SUBTRACTOR_ADD_EN
        test_mode();
`endif
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter N, default 8: operand and result width in bits, legal range 2..32.
REQ-002 SHALL have port CLK  input  1  rising-edge clock for all state.
REQ-003 SHALL have port RST  input  1  asynchronous active-high reset.
REQ-004 SHALL have port START  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have port X  input  N  minuend.
REQ-006 SHALL have port Y  input  N  subtrahend.
REQ-007 SHALL have port D  output  N  difference X-Y mod 2^N; registered.
REQ-008 SHALL have port B  output  1  final borrow: 1 when X<Y unsigned; registered.
REQ-009 SHALL have port BUSY  output  1  high while an operation is in progress.
REQ-010 SHALL have port DONE  output  1  one-cycle pulse marking D/B valid.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, FINISH.
REQ-012 SHALL, in IDLE with START=1 at a CLK edge, load X and Y into internal shift registers, clear the borrow flop and bit counter, and enter SHIFT.
REQ-013 SHALL, per SHIFT cycle, process one bit LSB-first: diff = x^y^bin; bout = (~x&y) | (~(x^y)&bin); shift diff into the result register MSB end; update the borrow flop.
REQ-014 SHALL stay in SHIFT exactly N cycles, then enter FINISH.
REQ-015 SHALL in FINISH drive D = result register, B = borrow flop, DONE=1 for one cycle, then return to IDLE.
REQ-016 SHALL assert DONE exactly N+1 cycles after the edge that sampled START.
REQ-017 SHALL assert BUSY in SHIFT and FINISH, deasserted in IDLE.
REQ-018 SHALL ignore START while not in IDLE; X/Y changes after capture SHALL NOT affect the result.
REQ-019 SHALL hold D and B stable from FINISH until the next FINISH.
REQ-020 SHALL accept START in the cycle DONE is high only as of the following IDLE cycle (back-to-back period N+2).

Reset
REQ-021 SHALL on RST=1, regardless of CLK, force state IDLE, D=0, B=0, BUSY=0, DONE=0, counter, borrow and shift registers to 0.
REQ-022 SHALL abort any in-progress operation on reset with no DONE pulse; the first START after RST deasserts is serviced normally.

Configuration
REQ-023 SHALL, when SERIAL_SUBTRACTOR_ADD_EN is defined, add input port MODE (1 bit, captured with START): MODE=0 subtract per REQ-013; MODE=1 add (sum=x^y^c; cout=x&y | c&(x^y)), with B reporting carry-out.
REQ-024 SHALL, when SERIAL_SUBTRACTOR_ADD_EN is undefined, have no MODE port and subtract only.

Structure
REQ-025 SHALL take state encodings (IDLE=2'd0, SHIFT=2'd1, FINISH=2'd2) and default N from shared package serial_arith_pkg, shared with future serial arithmetic blocks.
REQ-026 SHALL instantiate one combinational sub-module fullsubtractor (ports X, Y, BIN, D, BOUT) for the per-bit cell; mode-add logic sits beside it.

Verification
REQ-027 Bench SHALL cover: N=8, X=8'd100, Y=8'd58, START pulse -> DONE after 9 cycles, D=8'd42, B=0, BUSY high for 9 cycles.
REQ-028 Bench SHALL cover: X=8'd5, Y=8'd10 -> D=8'd251, B=1; X=8'd0, Y=8'd0 -> D=0, B=0.
REQ-029 Bench SHALL cover: START re-pulsed and X/Y changed during SHIFT -> ignored; result matches originally captured operands.
REQ-030 Bench SHALL cover: RST asserted mid-SHIFT (cycle 4) -> outputs 0 immediately, no DONE; next START with X=8'd200, Y=8'd1 -> D=8'd199, B=0.
REQ-031 Bench SHALL cover: with SERIAL_SUBTRACTOR_ADD_EN, MODE=1, X=8'd200, Y=8'd100 -> D=8'd44, B=1; MODE=0 same operands -> D=8'd100, B=0.
REQ-032 Bench SHALL cover: exhaustive N=4 sweep of all 256 X/Y pairs, back-to-back operations, checked against X-Y and borrow via $monitor-style table plus self-check.
